// File: rtl/qinst_timing_queue.sv
// qinst_timing_queue: circular FIFO of {inst, delta} feeding a timed issue FSM (IDLE/WAIT/ISSUE).
// Define QTQ_ISSUE_STATS_EN to build the issued_cnt statistics counter; otherwise issued_cnt reads 0.
module qinst_timing_queue #(
  parameter int DEPTH = 8,
  parameter int TW = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enq_valid,
  output logic enq_ready,
  input  logic [63:0] enq_inst,
  input  logic [TW-1:0] enq_delta,
  input  logic run,
  input  logic flush,
  output logic issue_valid,
  output logic [63:0] issue_inst,
  input  logic issue_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic busy,
  output logic ovf_err,
  output logic late_err,
  input  logic err_clr,
  output logic [31:0] issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
  state_t state;
  logic [63:0] inst_mem [DEPTH];
  logic [TW-1:0] delta_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] cnt, head_delta;
  logic [63:0] hold;
  logic push, pop;
  assign issue_valid = state == ISSUE;
  assign issue_inst = issue_valid ? hold : '0;
  assign enq_ready = level != LW'(DEPTH);
  assign busy = state != IDLE || level != '0;
  assign head_delta = delta_mem[rd_ptr];
  // level is registered, so a freshly written entry only becomes poppable next cycle
  assign push = rst_n && !flush && enq_valid && enq_ready;
  assign pop = rst_n && !flush && run && level != '0 && (state == IDLE || (issue_valid && issue_ack));
  always_ff @(posedge clk)
    if (push) begin
      inst_mem[wr_ptr] <= enq_inst;
      delta_mem[wr_ptr] <= enq_delta;
    end
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cnt <= '0;
      hold <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold <= inst_mem[rd_ptr];
        cnt <= head_delta;
        state <= head_delta == '0 ? ISSUE : WAIT;
      end else if (state == WAIT && run) begin
        cnt <= cnt - TW'(1);
        if (cnt == TW'(1)) state <= ISSUE;
      end else if (issue_valid && issue_ack) begin
        state <= IDLE;
      end
      level <= level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      ovf_err <= 1'b0;
      late_err <= 1'b0;
    end else begin
      ovf_err <= (enq_valid && !enq_ready) || (ovf_err && !err_clr);
      late_err <= (issue_valid && !issue_ack) || (late_err && !err_clr);
    end
`ifdef QTQ_ISSUE_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n || flush) issued_cnt <= '0;
    else if (issue_valid && issue_ack) issued_cnt <= issued_cnt + 32'd1;
`else
  assign issued_cnt = '0;
`endif
endmodule

// File: tb/tb_qinst_timing_queue.sv
// tb_qinst_timing_queue: directed scenarios then random traffic, checked against a queue-based model.
module tb_qinst_timing_queue;
  localparam int DEPTH = 8;
  localparam int TW = 6;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0, enq_valid = 0, run = 0, flush = 0, issue_ack = 0, err_clr = 0;
  logic [63:0] enq_inst = '0;
  logic [TW-1:0] enq_delta = '0;
  logic enq_ready, issue_valid, busy, ovf_err, late_err;
  logic [63:0] issue_inst;
  logic [LW-1:0] level;
  logic [31:0] issued_cnt;
  int errors = 0, checks = 0;

  typedef struct {logic [63:0] inst; int delta;} ent_t;
  ent_t q[$];
  bit held, mv, movf, mlate;
  logic [63:0] hinst;
  int wleft;
  int unsigned missued;

  always #5 clk = ~clk;

  qinst_timing_queue #(.DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_inst(enq_inst), .enq_delta(enq_delta), .run(run), .flush(flush),
    .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_ack(issue_ack),
    .level(level), .busy(busy), .ovf_err(ovf_err), .late_err(late_err),
    .err_clr(err_clr), .issued_cnt(issued_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Held entry waits wleft running cycles, then is presented until acked.
  task automatic model_edge();
    bit rdy, free;
    ent_t e;
    rdy = q.size() < DEPTH;
    if (!rst_n) begin
      q.delete(); held = 0; mv = 0; hinst = '0; wleft = 0; movf = 0; mlate = 0; missued = 0;
    end else begin
      movf = (enq_valid && !rdy) || (movf && !err_clr);
      mlate = (mv && !issue_ack) || (mlate && !err_clr);
      if (flush) begin
        q.delete(); held = 0; mv = 0; missued = 0;
      end else begin
        free = !held || (mv && issue_ack);
        if (mv && issue_ack) missued++;
        if (held && !mv && run) begin
          wleft--;
          if (wleft == 0) mv = 1;
        end
        if (free) begin
          if (run && q.size() > 0) begin
            e = q.pop_front();
            held = 1; hinst = e.inst; wleft = e.delta; mv = e.delta == 0;
          end else begin
            held = 0; mv = 0;
          end
        end
        if (enq_valid && rdy) q.push_back('{enq_inst, int'(enq_delta)});
      end
    end
  endtask

  task automatic check_outputs();
    chk("issue_valid", 64'(issue_valid), 64'(mv));
    chk("issue_inst", issue_inst, mv ? hinst : 64'd0);
    chk("level", 64'(level), 64'(q.size()));
    chk("enq_ready", 64'(enq_ready), 64'(q.size() < DEPTH));
    chk("busy", 64'(busy), 64'(held || q.size() != 0));
    chk("ovf_err", 64'(ovf_err), 64'(movf));
    chk("late_err", 64'(late_err), 64'(mlate));
`ifdef QTQ_ISSUE_STATS_EN
    chk("issued_cnt", 64'(issued_cnt), 64'(missued));
`else
    chk("issued_cnt", 64'(issued_cnt), 64'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic enq(input logic [63:0] inst, input int delta);
    enq_valid = 1; enq_inst = inst; enq_delta = TW'(delta);
    tick();
    enq_valid = 0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!issue_valid && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(issue_valid), 64'd1);
  endtask

  initial begin
    int n;
    // reset must override flush and enqueue
    rst_n = 0; enq_valid = 1; flush = 1; run = 1; issue_ack = 1;
    tick(); tick();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ready", 64'(enq_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1; enq_valid = 0; flush = 0; run = 0;
    // A delta 0 then B delta 3, ack tied high
    enq(64'hA, 0); enq(64'hB, 3);
    run = 1;
    tick();
    chk("a_valid", 64'(issue_valid), 64'd1);
    chk("a_inst", issue_inst, 64'hA);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_wait", 64'(issue_valid), 64'd0);
    end
    tick();
    chk("b_valid", 64'(issue_valid), 64'd1);
    chk("b_inst", issue_inst, 64'hB);
    tick();
`ifdef QTQ_ISSUE_STATS_EN
    chk("cnt_two", 64'(issued_cnt), 64'd2);
`endif
    // fill with run low, offer one too many
    run = 0;
    for (int i = 0; i < DEPTH; i++) enq(64'h100 + 64'(i), 0);
    chk("full_ready", 64'(enq_ready), 64'd0);
    enq(64'hDEAD, 0);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("full_level", 64'(level), 64'(DEPTH));
    run = 1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      chk("order_valid", 64'(issue_valid), 64'd1);
      chk("order_inst", issue_inst, 64'h100 + 64'(i));
    end
    tick();
    chk("drain_idle", 64'(busy), 64'd0);
    err_clr = 1; tick(); err_clr = 0;
    chk("ovf_clr", 64'(ovf_err), 64'd0);
    // late ack
    issue_ack = 0;
    enq(64'h55AA, 2);
    wait_valid("late_reach", n);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_stable", issue_inst, 64'h55AA);
      chk("late_flag", 64'(late_err), 64'd1);
    end
    issue_ack = 1; tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("late_clr", 64'(late_err), 64'd0);
    // freeze countdown at 5 for 4 cycles
    enq(64'h77, 7);
    tick(); tick(); tick();
    run = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frozen", 64'(issue_valid), 64'd0);
    end
    run = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("resume_wait", 64'(issue_valid), 64'd0);
    end
    tick();
    chk("resume_valid", 64'(issue_valid), 64'd1);
    chk("resume_inst", issue_inst, 64'h77);
    tick();
    // flush with held entry, level 3, and a same-cycle enqueue
    run = 0;
    for (int i = 0; i < 4; i++) enq(64'h200 + 64'(i), 0);
    run = 1; issue_ack = 0;
    tick();
    chk("pre_flush_level", 64'(level), 64'd3);
    chk("pre_flush_valid", 64'(issue_valid), 64'd1);
    flush = 1; enq_valid = 1; enq_inst = 64'hF00D; enq_delta = '0; issue_ack = 1;
    tick();
    flush = 0; enq_valid = 0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(issue_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_cnt", 64'(issued_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_gone", 64'(issue_valid), 64'd0);
    end
    err_clr = 1; tick(); err_clr = 0;
    // reset during WAIT
    enq(64'h99, 10);
    tick(); tick();
    rst_n = 0; tick(); rst_n = 1;
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_ready", 64'(enq_ready), 64'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("rstw_gone", 64'(issue_valid), 64'd0);
    end
    // maximum delta: valid delta+1 cycles after the pop cycle
    enq(64'hBEEF, (1 << TW) - 1);
    wait_valid("max_reach", n);
    chk("max_latency", 64'(n), 64'(1 << TW));
    tick();
    // random traffic
    for (int c = 0; c < 2500; c++) begin
      rst_n = $urandom_range(0, 199) != 0;
      flush = $urandom_range(0, 59) == 0;
      enq_valid = $urandom_range(0, 1);
      enq_inst = {$urandom, $urandom};
      enq_delta = $urandom_range(0, 15) == 0 ? TW'($urandom) : TW'($urandom_range(0, 4));
      run = $urandom_range(0, 4) != 0;
      issue_ack = $urandom_range(0, 9) < 7;
      err_clr = $urandom_range(0, 19) == 0;
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
